sata_phy_rx_align_monitor: RTL and testbench

- Receive-side companion to the PHY transmit path, which periodically inserts ALIGN primitive pairs.
- After OOB linkup, the block watches the received dword stream, acquires and tracks ALIGN-based dword sync, and strips ALIGN primitives out of the stream.
- It also flags decode errors, sync loss and missing-ALIGN timeouts.
- Output is a registered, filtered dword stream with a valid strobe, consumed by the link layer.

---
 rtl/sata_phy_rx_align_monitor.sv | 193 +++++++++++++++++++
 tb/tb_sata_phy_rx_align_monitor.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sata_phy_rx_align_monitor.sv
// SATA PHY receive-side ALIGN monitor.
// Acquires and tracks dword sync from ALIGN primitives, strips ALIGNs out of
// the received stream, and flags decode errors, sync loss and ALIGN timeouts.
// Every output is registered and reflects the dword presented one clk earlier.
module sata_phy_rx_align_monitor #(
  parameter int unsigned ACQUIRE_COUNT = 2,
  parameter int unsigned LOSS_ERRORS   = 4,
  parameter int unsigned ALIGN_TIMEOUT = 1024,
  parameter int unsigned CNT_WIDTH     = 11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        linkup,
  input  logic [31:0] rx_din,
  input  logic [3:0]  rx_is_k,
  input  logic        phy_error,
  output logic [31:0] rx_dout,
  output logic [3:0]  rx_is_k_out,
  output logic        rx_valid,
  output logic        rx_synced,
  output logic        align_detected,
  output logic        sync_lost,
  output logic        align_timeout,
  output logic [7:0]  error_count,
  output logic [1:0]  mon_state
);

  localparam logic [31:0] PRIM_ALIGN = 32'h7B4A_4ABC;
  localparam logic [3:0]  ALIGN_K    = 4'b0001;

  localparam int unsigned ACQ_W = (ACQUIRE_COUNT > 1) ? $clog2(ACQUIRE_COUNT + 1) : 1;
  localparam int unsigned ERR_W = (LOSS_ERRORS > 1) ? $clog2(LOSS_ERRORS + 1) : 1;

  localparam logic [ACQ_W-1:0]     ACQ_LAST = ACQ_W'(ACQUIRE_COUNT - 1);
  localparam logic [ERR_W-1:0]     ERR_LAST = ERR_W'(LOSS_ERRORS - 1);
  localparam logic [CNT_WIDTH-1:0] TO_LAST  = CNT_WIDTH'(ALIGN_TIMEOUT - 1);
  localparam logic [CNT_WIDTH-1:0] TO_MAX   = CNT_WIDTH'(ALIGN_TIMEOUT);

  typedef enum logic [1:0] {
    UNSYNC  = 2'd0,
    ACQUIRE = 2'd1,
    SYNC    = 2'd2
  } state_t;

  state_t               state, state_nxt;
  logic [ACQ_W-1:0]     acq_cnt, acq_nxt;
  logic [ERR_W-1:0]     err_cnt, err_nxt;
  logic [CNT_WIDTH-1:0] to_cnt, to_nxt;
  logic                 timeout_nxt;
  logic                 sync_lost_nxt;
  logic                 valid_nxt;
  logic                 clean_align;
  logic                 align_pattern;

  // Dword classification: an ALIGN carrying a decode error is never clean.
  assign align_pattern = (rx_din == PRIM_ALIGN);
  assign clean_align   = align_pattern && (rx_is_k == ALIGN_K) && !phy_error;

  // Next-state, counter and flag logic for the sync FSM.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    state_nxt     = state;
    acq_nxt       = acq_cnt;
    err_nxt       = err_cnt;
    to_nxt        = to_cnt;
    timeout_nxt   = align_timeout;
    sync_lost_nxt = 1'b0;
    valid_nxt     = (state == SYNC) && !clean_align && !phy_error && !align_pattern;

    if (!linkup) begin
      state_nxt     = UNSYNC;
      acq_nxt       = '0;
      err_nxt       = '0;
      to_nxt        = '0;
      timeout_nxt   = 1'b0;
      sync_lost_nxt = (state == SYNC);
    end else begin
      if (clean_align) begin
        timeout_nxt = 1'b0;
      end
      unique case (state)
        UNSYNC: begin
          acq_nxt = '0;
          err_nxt = '0;
          to_nxt  = '0;
          if (clean_align) begin
            if (ACQUIRE_COUNT == 1) begin
              state_nxt = SYNC;
            end else begin
              acq_nxt   = ACQ_W'(1);
              state_nxt = ACQUIRE;
            end
          end
        end
        ACQUIRE: begin
          if (phy_error) begin
            acq_nxt   = '0;
            state_nxt = UNSYNC;
          end else if (clean_align) begin
            if (acq_cnt == ACQ_LAST) begin
              acq_nxt   = '0;
              err_nxt   = '0;
              to_nxt    = '0;
              state_nxt = SYNC;
            end else begin
              acq_nxt = acq_cnt + ACQ_W'(1);
            end
          end
        end
        SYNC: begin
          if (clean_align) begin
            err_nxt = '0;
            to_nxt  = '0;
          end else begin
            // The counter parks one past the last legal value once it fires.
            if (to_cnt >= TO_LAST) begin
              to_nxt      = TO_MAX;
              timeout_nxt = 1'b1;
            end else begin
              to_nxt = to_cnt + CNT_WIDTH'(1);
            end
            if (phy_error) begin
              if (err_cnt == ERR_LAST) begin
                err_nxt       = '0;
                to_nxt        = '0;
                state_nxt     = UNSYNC;
                sync_lost_nxt = 1'b1;
              end else begin
                err_nxt = err_cnt + ERR_W'(1);
              end
            end
          end
        end
        default: begin
          state_nxt = UNSYNC;
          acq_nxt   = '0;
          err_nxt   = '0;
          to_nxt    = '0;
        end
      endcase
    end
  end

  // FSM state and internal counters.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      state   <= UNSYNC;
      acq_cnt <= '0;
      err_cnt <= '0;
      to_cnt  <= '0;
    end else begin
      state   <= state_nxt;
      acq_cnt <= acq_nxt;
      err_cnt <= err_nxt;
      to_cnt  <= to_nxt;
    end
  end

  // Registered output stream and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_dout        <= '0;
      rx_is_k_out    <= '0;
      rx_valid       <= 1'b0;
      align_detected <= 1'b0;
      sync_lost      <= 1'b0;
      align_timeout  <= 1'b0;
    end else begin
      rx_dout        <= rx_din;
      rx_is_k_out    <= rx_is_k;
      rx_valid       <= valid_nxt;
      align_detected <= clean_align;
      sync_lost      <= sync_lost_nxt;
      align_timeout  <= timeout_nxt;
    end
  end

  // Saturating decode-error counter; survives linkup drops, cleared only by rst.
  always_ff @(posedge clk) begin
    if (rst) begin
      error_count <= '0;
    end else if (linkup && phy_error && (error_count != 8'hFF)) begin
      error_count <= error_count + 8'd1;
    end
  end

  assign rx_synced = (state == SYNC);
  assign mon_state = state;

endmodule

// File: tb/tb_sata_phy_rx_align_monitor.sv
// Scoreboard bench for sata_phy_rx_align_monitor: a behavioural model predicts
// each output cycle when a dword is driven, the prediction is queued, and it is
// popped and compared field by field one clk later.
module tb_sata_phy_rx_align_monitor;

  localparam logic [31:0] ALIGN    = 32'h7B4A_4ABC;
  localparam int          ACQ_CNT  = 2;
  localparam int          LOSS_ERR = 4;
  localparam int          TIMEOUT  = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        linkup = 1'b0;
  logic [31:0] rx_din = '0;
  logic [3:0]  rx_is_k = '0;
  logic        phy_error = 1'b0;
  logic [31:0] rx_dout;
  logic [3:0]  rx_is_k_out;
  logic        rx_valid;
  logic        rx_synced;
  logic        align_detected;
  logic        sync_lost;
  logic        align_timeout;
  logic [7:0]  error_count;
  logic [1:0]  mon_state;

  sata_phy_rx_align_monitor #(
    .ACQUIRE_COUNT(ACQ_CNT),
    .LOSS_ERRORS  (LOSS_ERR),
    .ALIGN_TIMEOUT(TIMEOUT),
    .CNT_WIDTH    (11)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .linkup        (linkup),
    .rx_din        (rx_din),
    .rx_is_k       (rx_is_k),
    .phy_error     (phy_error),
    .rx_dout       (rx_dout),
    .rx_is_k_out   (rx_is_k_out),
    .rx_valid      (rx_valid),
    .rx_synced     (rx_synced),
    .align_detected(align_detected),
    .sync_lost     (sync_lost),
    .align_timeout (align_timeout),
    .error_count   (error_count),
    .mon_state     (mon_state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] dout;
    logic [3:0]  k;
    logic        valid;
    logic        synced;
    logic        align;
    logic        lost;
    logic        timeout;
    logic [7:0]  ecnt;
    logic [1:0]  state;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model state.
  int m_state = 0;
  int m_acq   = 0;
  int m_err   = 0;
  int m_to    = 0;
  bit m_tmo   = 1'b0;
  int m_ecnt  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_state = 0; m_acq = 0; m_err = 0; m_to = 0; m_tmo = 1'b0; m_ecnt = 0;
  endfunction

  function automatic exp_t model_step(input logic [31:0] d, input logic [3:0] k,
                                      input logic perr, input logic link);
    exp_t e;
    bit   clean;
    clean   = (d == ALIGN) && (k == 4'b0001) && !perr;
    e       = '0;
    e.dout  = d;
    e.k     = k;
    e.align = clean;
    e.valid = (m_state == 2) && !clean && !perr && (d != ALIGN);
    if (link && perr && m_ecnt < 255) m_ecnt++;
    if (!link) begin
      e.lost  = (m_state == 2);
      m_state = 0; m_acq = 0; m_err = 0; m_to = 0; m_tmo = 1'b0;
    end else begin
      if (clean) m_tmo = 1'b0;
      case (m_state)
        0: if (clean) begin
             m_acq   = 1;
             m_state = (ACQ_CNT == 1) ? 2 : 1;
           end
        1: if (perr) begin
             m_acq = 0; m_state = 0;
           end else if (clean) begin
             m_acq++;
             if (m_acq == ACQ_CNT) begin
               m_state = 2; m_acq = 0; m_err = 0; m_to = 0;
             end
           end
        default: if (clean) begin
             m_err = 0; m_to = 0;
           end else begin
             m_to++;
             if (m_to >= TIMEOUT) begin
               m_to = TIMEOUT; m_tmo = 1'b1;
             end
             if (perr) begin
               m_err++;
               if (m_err == LOSS_ERR) begin
                 m_state = 0; m_err = 0; m_to = 0; e.lost = 1'b1;
               end
             end
           end
      endcase
    end
    e.state   = 2'(m_state);
    e.synced  = (m_state == 2);
    e.timeout = m_tmo;
    e.ecnt    = 8'(m_ecnt);
    return e;
  endfunction

  task automatic compare();
    exp_t x;
    if (sb.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
      return;
    end
    x = sb.pop_front();
    check("rx_dout",        rx_dout,        x.dout);
    check("rx_is_k_out",    {28'd0, rx_is_k_out}, {28'd0, x.k});
    check("rx_valid",       {31'd0, rx_valid},       {31'd0, x.valid});
    check("rx_synced",      {31'd0, rx_synced},      {31'd0, x.synced});
    check("align_detected", {31'd0, align_detected}, {31'd0, x.align});
    check("sync_lost",      {31'd0, sync_lost},      {31'd0, x.lost});
    check("align_timeout",  {31'd0, align_timeout},  {31'd0, x.timeout});
    check("error_count",    {24'd0, error_count},    {24'd0, x.ecnt});
    check("mon_state",      {30'd0, mon_state},      {30'd0, x.state});
  endtask

  task automatic drive(input logic [31:0] d, input logic [3:0] k,
                       input logic perr, input logic link);
    rx_din    = d;
    rx_is_k   = k;
    phy_error = perr;
    linkup    = link;
    sb.push_back(model_step(d, k, perr, link));
    @(posedge clk);
    #1;
    compare();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    sb.push_back('0);
    @(posedge clk);
    #1;
    compare();
    rst = 1'b0;
  endtask

  task automatic send_align();
    drive(ALIGN, 4'b0001, 1'b0, 1'b1);
  endtask

  task automatic send_data(input logic [31:0] d);
    drive(d, 4'b0000, 1'b0, 1'b1);
  endtask

  task automatic send_err(input logic [31:0] d);
    drive(d, 4'b0000, 1'b1, 1'b1);
  endtask

  initial begin
    logic [31:0] r;
    @(posedge clk);
    #1;

    // Reset state, then acquisition: 0 -> 1 -> 2.
    do_reset();
    send_data(32'hCAFE_0001);
    send_align();
    check("acq_state", {30'd0, mon_state}, 32'd1);
    send_align();
    check("sync_state", {31'd0, rx_synced}, 32'd1);

    // ALIGNs stripped, data passes through.
    send_align();
    send_align();
    send_data(32'h1234_5678);
    check("d0_out", rx_dout, 32'h1234_5678);
    send_data(32'hDEAD_BEEF);

    // Errors below the loss threshold, reset by ALIGN, then loss.
    for (int i = 0; i < 3; i++) send_err(32'h0BAD_0000 + i);
    send_align();
    for (int i = 0; i < 3; i++) send_err(32'h0BAD_1000 + i);
    check("ecnt6", {24'd0, error_count}, 32'd6);
    send_err(32'h0BAD_2000);
    check("lost_pulse", {31'd0, sync_lost}, 32'd1);
    send_data(32'h0000_0042);

    // Re-sync and run into the ALIGN timeout.
    send_align();
    send_align();
    for (int i = 0; i < TIMEOUT; i++) send_data(32'h5000_0000 + i);
    check("timeout_set", {31'd0, align_timeout}, 32'd1);
    send_data(32'h5555_AAAA);
    send_align();
    check("timeout_clr", {31'd0, align_timeout}, 32'd0);

    // ALIGN carrying an error is neither clean nor valid.
    drive(ALIGN, 4'b0001, 1'b1, 1'b1);
    drive(ALIGN, 4'b0011, 1'b0, 1'b1);

    // Break acquisition with an error dword.
    drive(32'h0, 4'b0, 1'b0, 1'b0);
    send_align();
    send_err(32'hEEEE_0001);
    check("acq_abort", {30'd0, mon_state}, 32'd0);
    send_align();
    send_data(32'h7777_0000);
    send_align();

    // Timeout again, then drop linkup while synced.
    for (int i = 0; i < TIMEOUT + 3; i++) send_data(32'h6000_0000 + i);
    drive(32'h1111_2222, 4'b0000, 1'b0, 1'b0);
    drive(32'h1111_3333, 4'b0000, 1'b1, 1'b0);

    // Reset in the middle of acquisition.
    send_align();
    rx_din = ALIGN; rx_is_k = 4'b0001; phy_error = 1'b0; linkup = 1'b1;
    do_reset();
    send_align();
    send_align();

    // Random mix.
    for (int i = 0; i < 600; i++) begin
      r = $urandom;
      if ($urandom_range(0, 49) == 0) begin
        drive(r, 4'(r[7:4]), r[0], 1'b0);
      end else begin
        case ($urandom_range(0, 9))
          0, 1, 2, 3: send_align();
          4:          drive(ALIGN, 4'b0001, 1'b1, 1'b1);
          5:          send_err(r);
          6:          drive(ALIGN, 4'b1001, 1'b0, 1'b1);
          default:    send_data(r);
        endcase
      end
    end

    if (sb.size() != 0) check("sb_leftover", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
